// File: rtl/io_bus_arbiter.sv
// Two-master arbiter and address decoder for the 0xFFFFFCxx I/O window.
// Define IO_ERR_IRQ_EN to add the err_irq pulse output for unmapped accesses.
module io_bus_arbiter #(
    parameter int unsigned WAIT_CYCLES       = 2,
    parameter bit          M0_PRIORITY_FIRST = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [15:0] m0_addr,
    input  logic [15:0] m0_wdata,
    output logic        m0_ack,
    output logic [15:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [15:0] m1_addr,
    input  logic [15:0] m1_wdata,
    output logic        m1_ack,
    output logic [15:0] m1_rdata,
    output logic [2:0]  io_addr,
    output logic [15:0] io_wdata,
    output logic        io_read_enable,
    output logic        io_write_enable,
    output logic        key_ctrl,
    output logic        timer_ctrl,
    output logic        led_ctrl,
    output logic        switch_ctrl,
    input  logic [15:0] key_rdata,
    input  logic [15:0] timer_rdata,
    input  logic [15:0] switch_rdata,
`ifdef IO_ERR_IRQ_EN
    output logic        err_irq,
`endif
    output logic        bus_err
);

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;
    typedef enum logic [2:0] {SelNone, SelKey, SelTimer, SelLed, SelSwitch} sel_e;

    state_e      state_q;
    sel_e        sel_q;
    logic [3:0]  cnt_q;
    logic        we_q;
    logic        grant_m1_q;
    logic        last_m1_q;   // 1: M1 was granted most recently
`ifndef IO_ERR_IRQ_EN
    logic        err_irq;
`endif

    logic        grant_m1;
    logic        req_we;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    sel_e        req_sel;
    logic [15:0] rd_value;
    logic        unused_addr_bit;

    function automatic sel_e decode(input logic [11:0] addr_hi);
        sel_e sel;
        sel = SelNone;
        if (addr_hi[11:4] == 8'hFC) begin
            case (addr_hi[3:0])
                4'h1:    sel = SelKey;
                4'h2:    sel = SelTimer;
                4'h6:    sel = SelLed;
                4'h7:    sel = SelSwitch;
                default: sel = SelNone;
            endcase
        end
        return sel;
    endfunction

    always_comb begin
        // Round-robin on contention: grant M1 only if M0 is idle or M0 was served last.
        grant_m1  = m1_req && (!m0_req || !last_m1_q);
        req_we    = grant_m1 ? m1_we    : m0_we;
        req_addr  = grant_m1 ? m1_addr  : m0_addr;
        req_wdata = grant_m1 ? m1_wdata : m0_wdata;
        req_sel   = decode(req_addr[15:4]);
        unused_addr_bit = req_addr[3];

        rd_value = 16'h0000;
        if (!we_q) begin
            case (sel_q)
                SelKey:    rd_value = key_rdata;
                SelTimer:  rd_value = timer_rdata;
                SelSwitch: rd_value = switch_rdata;
                default:   rd_value = 16'h0000;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= StIdle;
            sel_q           <= SelNone;
            cnt_q           <= 4'd0;
            we_q            <= 1'b0;
            grant_m1_q      <= 1'b0;
            last_m1_q       <= M0_PRIORITY_FIRST;
            m0_ack          <= 1'b0;
            m0_rdata        <= 16'h0000;
            m1_ack          <= 1'b0;
            m1_rdata        <= 16'h0000;
            io_addr         <= 3'd0;
            io_wdata        <= 16'h0000;
            io_read_enable  <= 1'b0;
            io_write_enable <= 1'b0;
            key_ctrl        <= 1'b0;
            timer_ctrl      <= 1'b0;
            led_ctrl        <= 1'b0;
            switch_ctrl     <= 1'b0;
            err_irq         <= 1'b0;
            bus_err         <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (m0_req || m1_req) begin
                        grant_m1_q      <= grant_m1;
                        last_m1_q       <= grant_m1;
                        we_q            <= req_we;
                        sel_q           <= req_sel;
                        cnt_q           <= 4'(WAIT_CYCLES - 1);
                        io_addr         <= req_addr[2:0];
                        io_wdata        <= req_wdata;
                        key_ctrl        <= (req_sel == SelKey);
                        timer_ctrl      <= (req_sel == SelTimer);
                        led_ctrl        <= (req_sel == SelLed);
                        switch_ctrl     <= (req_sel == SelSwitch);
                        io_read_enable  <= !req_we && (req_sel != SelNone);
                        io_write_enable <= req_we && (req_sel != SelNone);
                        state_q         <= StAccess;
                    end
                end
                StAccess: begin
                    if (cnt_q == 4'd0) begin
                        io_addr         <= 3'd0;
                        io_wdata        <= 16'h0000;
                        key_ctrl        <= 1'b0;
                        timer_ctrl      <= 1'b0;
                        led_ctrl        <= 1'b0;
                        switch_ctrl     <= 1'b0;
                        io_read_enable  <= 1'b0;
                        io_write_enable <= 1'b0;
                        if (grant_m1_q) begin
                            m1_ack   <= 1'b1;
                            m1_rdata <= rd_value;
                        end else begin
                            m0_ack   <= 1'b1;
                            m0_rdata <= rd_value;
                        end
                        if (sel_q == SelNone) begin
                            bus_err <= 1'b1;
                            err_irq <= 1'b1;
                        end
                        state_q <= StDone;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StDone: begin
                    m0_ack  <= 1'b0;
                    m1_ack  <= 1'b0;
                    err_irq <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed self-checking bench for io_bus_arbiter (WAIT_CYCLES=2, M0 first on contention).
module tb_io_bus_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [15:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_ack, m1_ack;
    logic [15:0] m0_rdata, m1_rdata;
    logic [2:0]  io_addr;
    logic [15:0] io_wdata;
    logic        io_read_enable, io_write_enable;
    logic        key_ctrl, timer_ctrl, led_ctrl, switch_ctrl;
    logic [15:0] key_rdata, timer_rdata, switch_rdata;
    logic        bus_err;
`ifdef IO_ERR_IRQ_EN
    logic        err_irq;
`endif

    int checks = 0;
    int errors = 0;

    io_bus_arbiter #(
        .WAIT_CYCLES       (2),
        .M0_PRIORITY_FIRST (1'b1)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .m0_req          (m0_req),
        .m0_we           (m0_we),
        .m0_addr         (m0_addr),
        .m0_wdata        (m0_wdata),
        .m0_ack          (m0_ack),
        .m0_rdata        (m0_rdata),
        .m1_req          (m1_req),
        .m1_we           (m1_we),
        .m1_addr         (m1_addr),
        .m1_wdata        (m1_wdata),
        .m1_ack          (m1_ack),
        .m1_rdata        (m1_rdata),
        .io_addr         (io_addr),
        .io_wdata        (io_wdata),
        .io_read_enable  (io_read_enable),
        .io_write_enable (io_write_enable),
        .key_ctrl        (key_ctrl),
        .timer_ctrl      (timer_ctrl),
        .led_ctrl        (led_ctrl),
        .switch_ctrl     (switch_ctrl),
        .key_rdata       (key_rdata),
        .timer_rdata     (timer_rdata),
        .switch_rdata    (switch_rdata),
`ifdef IO_ERR_IRQ_EN
        .err_irq         (err_irq),
`endif
        .bus_err         (bus_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [63:0] all_outs();
        return {4'd0, m0_ack, m0_rdata, m1_ack, m1_rdata, io_addr, io_wdata,
                io_read_enable, io_write_enable, key_ctrl, timer_ctrl, led_ctrl,
                switch_ctrl, bus_err};
    endfunction

    function automatic logic [5:0] strobes();
        return {key_ctrl, timer_ctrl, led_ctrl, switch_ctrl, io_read_enable, io_write_enable};
    endfunction

    initial begin
        reset = 1'b1;
        {m0_req, m0_we, m1_req, m1_we} = '0;
        {m0_addr, m0_wdata, m1_addr, m1_wdata} = '0;
        {key_rdata, timer_rdata, switch_rdata} = '0;
        #2;
        chk("reset_outputs", all_outs(), 64'd0);
        #10 reset = 1'b0;
        tick();

        // M0 keypad read
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'hFC10; key_rdata = 16'h0D7E;
        tick();
        chk("kp0_access1", {key_ctrl, io_read_enable, io_addr, m0_ack}, {1'b1, 1'b1, 3'd0, 1'b0});
        tick();
        chk("kp0_access2", {key_ctrl, io_read_enable, m0_ack}, 3'b110);
        tick();
        chk("kp0_ack", {m0_ack, m0_rdata}, {1'b1, 16'h0D7E});
        chk("kp0_done_strobes", strobes(), 6'd0);
        m0_req = 1'b0;
        tick();
        chk("kp0_ack_one_cycle", m0_ack, 1'b0);

        // M1 keypad status read
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 16'hFC12; key_rdata = 16'h1234;
        tick();
        chk("kp1_access", {key_ctrl, io_read_enable, io_addr}, {2'b11, 3'b010});
        tick();
        tick();
        chk("kp1_ack", {m1_ack, m1_rdata, m0_ack}, {1'b1, 16'h1234, 1'b0});
        chk("kp1_m0_rdata_hold", m0_rdata, 16'h0D7E);
        m1_req = 1'b0;
        tick();

        // Contention: M0 timer read vs M1 switch read, both held high
        m0_req = 1'b1; m0_addr = 16'hFC20; timer_rdata = 16'h1111;
        m1_req = 1'b1; m1_addr = 16'hFC70; switch_rdata = 16'h2222;
        for (int g = 0; g < 4; g++) begin
            tick();
            if (g % 2 == 0) chk("cont_sel_m0", {timer_ctrl, switch_ctrl}, 2'b10);
            else            chk("cont_sel_m1", {timer_ctrl, switch_ctrl}, 2'b01);
            tick();
            tick();
            if (g % 2 == 0) chk("cont_ack_m0", {m0_ack, m1_ack, m0_rdata}, {2'b10, 16'h1111});
            else            chk("cont_ack_m1", {m0_ack, m1_ack, m1_rdata}, {2'b01, 16'h2222});
            if (g == 3) begin
                m0_req = 1'b0;
                m1_req = 1'b0;
            end
            tick();
            chk("cont_idle_no_ack", {m0_ack, m1_ack}, 2'b00);
        end

        // M0 LED write
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 16'hFC60; m0_wdata = 16'hA5A5;
        tick();
        chk("led_access1", {strobes(), io_wdata}, {6'b001001, 16'hA5A5});
        tick();
        chk("led_access2", {strobes(), io_wdata, m0_ack}, {6'b001001, 16'hA5A5, 1'b0});
        tick();
        chk("led_ack", {m0_ack, strobes()}, {1'b1, 6'd0});
        chk("led_no_bus_err", bus_err, 1'b0);
        m0_req = 1'b0; m0_we = 1'b0;
        tick();

        // Unmapped read
        m0_req = 1'b1; m0_addr = 16'hFC50;
        tick();
        chk("unmapped_access1", strobes(), 6'd0);
        tick();
        chk("unmapped_access2", {strobes(), m0_ack}, 7'd0);
        tick();
        chk("unmapped_ack", {m0_ack, m0_rdata, bus_err}, {1'b1, 16'h0000, 1'b1});
`ifdef IO_ERR_IRQ_EN
        chk("err_irq_pulse", err_irq, 1'b1);
`endif
        m0_req = 1'b0;
        tick();
        chk("bus_err_sticky1", {bus_err, m0_ack}, 2'b10);
`ifdef IO_ERR_IRQ_EN
        chk("err_irq_cleared", err_irq, 1'b0);
`endif
        tick();
        chk("bus_err_sticky2", bus_err, 1'b1);

        // Reset during first ACCESS cycle, then re-serve the pending M1 request
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 16'hFC10; key_rdata = 16'h0BEE;
        tick();
        chk("rst_pre_access", key_ctrl, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("rst_async_clear", all_outs(), 64'd0);
        tick();
        chk("rst_held_no_ack", {m1_ack, m0_ack}, 2'b00);
        #3 reset = 1'b0;
        tick();
        chk("rst_reserve_access", {key_ctrl, io_read_enable, m1_ack}, 3'b110);
        tick();
        tick();
        chk("rst_reserve_ack", {m1_ack, m1_rdata}, {1'b1, 16'h0BEE});
        m1_req = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
